// File: rtl/sync_filter_bank.sv
`default_nettype none
// ============================================================================
//  Module   : sync_filter_bank
//  Purpose  : Bank of independent single-bit clock-domain-crossing
//             synchronizers, each followed by a debounce filter and an
//             edge detector.  A channel's filtered output only follows its
//             synchronized input after FILTER_CYCLES consecutive samples
//             that disagree with the current output.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    CHANNELS      - number of independent asynchronous inputs
//    SYNC_STAGE    - synchronizer depth per channel (>= 2)
//    FILTER_CYCLES - consecutive disagreeing samples needed to flip dout (>= 1)
//    RESET_VAL     - per-channel reset level of sync stages and dout
//  Ports
//    clk           - destination clock, rising edge
//    async_reset   - asynchronous active-high reset, synchronous release
//    din           - asynchronous level inputs
//    filter_bypass - 1: dout follows the synchronizer output every edge
//    dout          - synchronized, filtered level per channel
//    rise_pulse    - one-cycle pulse on a dout 0->1 transition
//    fall_pulse    - one-cycle pulse on a dout 1->0 transition
//    changed       - one-cycle pulse when any channel's dout changes
// ============================================================================
module sync_filter_bank #(
    parameter int                  CHANNELS      = 8,
    parameter int                  SYNC_STAGE    = 3,
    parameter int                  FILTER_CYCLES = 4,
    parameter logic [CHANNELS-1:0] RESET_VAL     = '0
) (
    input  logic                clk,
    input  logic                async_reset,
    input  logic [CHANNELS-1:0] din,
    input  logic                filter_bypass,
    output logic [CHANNELS-1:0] dout,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic                changed
);

    // Guarded so an illegal FILTER_CYCLES reaches the elaboration error below
    // instead of tripping over a zero-width counter first.
    localparam int C_CNT_W = (FILTER_CYCLES < 1) ? 1 : $clog2(FILTER_CYCLES + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(FILTER_CYCLES - 1);

    generate
        if (SYNC_STAGE < 2) begin : g_bad_sync_stage
            $error("sync_filter_bank: SYNC_STAGE must be at least 2");
        end
        if (FILTER_CYCLES < 1) begin : g_bad_filter_cycles
            $error("sync_filter_bank: FILTER_CYCLES must be at least 1");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    // Bit 0 is the first (metastable-capturing) stage, bit SYNC_STAGE-1 the
    // last.  Nothing but wiring sits between stages.
    (* ASYNC_REG = "TRUE" *)
    logic [SYNC_STAGE-1:0] r_sync_q [CHANNELS];
    logic [SYNC_STAGE-1:0] w_sync_d [CHANNELS];

    logic [C_CNT_W-1:0]    r_cnt_q  [CHANNELS];
    logic [C_CNT_W-1:0]    w_cnt_d  [CHANNELS];

    logic [CHANNELS-1:0]   r_dout_q;
    logic [CHANNELS-1:0]   w_dout_d;
    logic [CHANNELS-1:0]   r_rise_q;
    logic [CHANNELS-1:0]   w_rise_d;
    logic [CHANNELS-1:0]   r_fall_q;
    logic [CHANNELS-1:0]   w_fall_d;
    logic                  r_changed_q;
    logic                  w_changed_d;

    logic [CHANNELS-1:0]   w_sync_out;

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_sync_out
            assign w_sync_out[g] = r_sync_q[g][SYNC_STAGE-1];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_dout_d = r_dout_q;
        w_rise_d = '0;
        w_fall_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_sync_d[i] = {r_sync_q[i][SYNC_STAGE-2:0], din[i]};
            w_cnt_d[i]  = r_cnt_q[i];

            if (filter_bypass) begin
                // Counter is parked at zero so leaving bypass starts a fresh
                // qualification window.
                w_cnt_d[i]  = '0;
                w_dout_d[i] = w_sync_out[i];
            end else if (w_sync_out[i] == r_dout_q[i]) begin
                // Input agrees with output again: any partial run was a glitch.
                w_cnt_d[i] = '0;
            end else if (r_cnt_q[i] == C_CNT_MAX) begin
                // This edge is the FILTER_CYCLES-th consecutive disagreement.
                w_cnt_d[i]  = '0;
                w_dout_d[i] = w_sync_out[i];
            end else begin
                w_cnt_d[i] = r_cnt_q[i] + C_CNT_W'(1);
            end

            // Pulses are derived from the dout transition itself so they are
            // registered on exactly the edge dout changes, in either mode.
            w_rise_d[i] =  w_dout_d[i] & ~r_dout_q[i];
            w_fall_d[i] = ~w_dout_d[i] &  r_dout_q[i];
        end
        w_changed_d = (|w_rise_d) | (|w_fall_d);
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_sync_q[i] <= {SYNC_STAGE{RESET_VAL[i]}};
                r_cnt_q[i]  <= '0;
            end
            r_dout_q    <= RESET_VAL;
            r_rise_q    <= '0;
            r_fall_q    <= '0;
            r_changed_q <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_sync_q[i] <= w_sync_d[i];
                r_cnt_q[i]  <= w_cnt_d[i];
            end
            r_dout_q    <= w_dout_d;
            r_rise_q    <= w_rise_d;
            r_fall_q    <= w_fall_d;
            r_changed_q <= w_changed_d;
        end
    end

    assign dout       = r_dout_q;
    assign rise_pulse = r_rise_q;
    assign fall_pulse = r_fall_q;
    assign changed    = r_changed_q;

endmodule
`default_nettype wire
